piso_word_serializer: RTL
=========================

Name: piso_word_serializer

Overview:
Parallel-in/serial-out transmitter, the counterpart of the serial-in shift register in the same design. It collects WIDTH/8 bytes from the 8-bit dedicated-input bus over a valid/ready handshake, then shifts the assembled word out MSB-first on one pin, one bit every DIV clocks. Framing strobes mark the first and last bit. It sits between the top-level input bus and a single output pin.

Parameters:
WIDTH, 32, word length in bits; multiple of 8, >= 8; NBYTES = WIDTH/8
DIV, 1, clocks per serial bit; >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  8  byte to load
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block accepts a byte this cycle
ser_out  output  1  serial data, MSB of word first
ser_valid  output  1  ser_out carries a word bit
ser_first  output  1  high during the bit period of word bit WIDTH-1
ser_last  output  1  high during the bit period of word bit 0
busy  output  1  high while in SHIFT state

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). All state is updated on the rising edge of clk.
- States: LOAD and SHIFT. in_ready = (state==LOAD). busy = (state==SHIFT).
- Reset, including assertion in mid-operation: at the next edge, state=LOAD, byte counter=0, bit counter=0, divider=0, shift register=0, and ser_out/ser_valid/ser_first/ser_last=0. Any partial or in-flight word is discarded. After reset, in_ready=1 and busy=0.
- LOAD state:
  - A byte is accepted on any edge where in_valid && in_ready.
  - The k-th accepted byte (k=0..NBYTES-1) is written to word bits [WIDTH-1-8k : WIDTH-8-8k], so the first byte is the most significant.
  - Gaps in in_valid are allowed; the partial word is held indefinitely.
  - On the edge that accepts byte NBYTES-1: state->SHIFT, bit counter=0, divider=0.
- SHIFT state:
  - In the first cycle after the final accept: ser_valid=1, ser_first=1, ser_out=word[WIDTH-1]. Load-to-first-bit latency is therefore 1 edge.
  - Each bit is held for exactly DIV cycles. The divider counts 0..DIV-1; when it wraps, the shifter moves to the next lower bit.
  - ser_first is high for all DIV cycles of bit WIDTH-1 only. ser_last is high for all DIV cycles of bit 0 only. For WIDTH=8 the two are never high together.
  - When the last cycle of bit 0 ends: state->LOAD, and ser_valid, ser_first, ser_last and ser_out all go to 0. in_ready=1 from that cycle on.
  - Total ser_valid high time per word is WIDTH*DIV cycles, with no gaps.
- in_valid during SHIFT is ignored because in_ready=0; nothing is accepted and nothing is lost inside the block.
- Minimum gap between words: ser_valid is low for at least NBYTES cycles between words, since there is no double buffering.
- When ser_valid=0, ser_out is held at 0 (idle level).
- All serial outputs come directly from flops, with no combinational path from inputs. in_ready and busy are decoded from the state flop only.
- Counter widths: byte counter is clog2(NBYTES) bits (minimum 1), bit counter is clog2(WIDTH) bits, divider is clog2(DIV) bits (minimum 1). No overflow is possible within legal parameters.

Test Plan:
- WIDTH=32, DIV=1: send bytes A5,0F,F0,3C on consecutive cycles -> ser_valid high 32 cycles starting the cycle after the 4th accept. ser_out stream = 1010_0101_0000_1111_1111_0000_0011_1100. ser_first only on cycle 1, ser_last only on cycle 32. in_ready=0 throughout, then 1.
- WIDTH=32, DIV=3: bytes 80,00,00,01 -> ser_out high for cycles 1-3, low for cycles 4-93, high for cycles 94-96. ser_valid high for exactly 96 cycles. ser_last high for cycles 94-96.
- Byte gaps: in_valid pulsed with 5 idle cycles between bytes FF,00,FF,00 -> no serial activity until the 4th accept. Stream is 8x1, 8x0, 8x1, 8x0.
- Ignored input: in_valid held high with data 55 during SHIFT -> no accept, and the word in progress is unchanged. After ser_last, bytes are accepted again, and the next word's 4 accepted bytes are all 55.
- Reset mid-shift: assert rst for 1 cycle at bit 10 of word DEADBEEF -> ser_valid=0 at the next edge and in_ready=1. A following word 12345678 serializes correctly with no leftover bits from the first word.
- WIDTH=8, DIV=2: single byte C3 -> 16 cycles of ser_valid. Stream pairs 11,11,00,00,00,00,11,11. ser_first for cycles 1-2, ser_last for cycles 15-16.

Source files
------------

// File: rtl/piso_word_serializer.sv
// Parallel-in/serial-out word transmitter.
// Collects WIDTH/8 bytes (first byte most significant) over a valid/ready
// handshake, then shifts the word out MSB-first, one bit every DIV clocks,
// with first/last framing strobes. All serial outputs are registered.
module piso_word_serializer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_first,
    output logic       ser_last,
    output logic       busy
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned BITW   = $clog2(WIDTH);
    localparam int unsigned DVW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BCW-1:0]  ByteLast  = BCW'(NBYTES - 1);
    localparam logic [BITW-1:0] BitLast   = BITW'(WIDTH - 1);
    localparam logic [BITW-1:0] BitPenult = BITW'(WIDTH - 2);
    localparam logic [DVW-1:0]  DivLast   = DVW'(DIV - 1);

    typedef enum logic {StLoad, StShift} state_e;

    state_e            r_state;
    logic [BCW-1:0]    r_byte_cnt;
    logic [BITW-1:0]   r_bit_cnt;
    logic [DVW-1:0]    r_div;
    logic [WIDTH-1:0]  r_shift;
    logic              r_ser_out;
    logic              r_ser_valid;
    logic              r_ser_first;
    logic              r_ser_last;

    state_e            w_state_nxt;
    logic [BCW-1:0]    w_byte_cnt_nxt;
    logic [BITW-1:0]   w_bit_cnt_nxt;
    logic [DVW-1:0]    w_div_nxt;
    logic [WIDTH-1:0]  w_shift_nxt;
    logic              w_ser_out_nxt;
    logic              w_ser_valid_nxt;
    logic              w_ser_first_nxt;
    logic              w_ser_last_nxt;
    logic [WIDTH-1:0]  w_shifted;

    assign w_shifted = r_shift << 1;

    // Next-state logic: byte assembly in LOAD, bit pacing and framing in SHIFT.
    always_comb begin
        w_state_nxt     = r_state;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_div_nxt       = r_div;
        w_shift_nxt     = r_shift;
        w_ser_out_nxt   = r_ser_out;
        w_ser_valid_nxt = r_ser_valid;
        w_ser_first_nxt = r_ser_first;
        w_ser_last_nxt  = r_ser_last;

        unique case (r_state)
            StLoad: begin
                if (in_valid) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (r_byte_cnt == BCW'(k)) begin
                            w_shift_nxt[WIDTH-1-8*k -: 8] = in_data;
                        end
                    end
                    if (r_byte_cnt == ByteLast) begin
                        // Word complete: first bit appears on the very next cycle.
                        w_byte_cnt_nxt  = '0;
                        w_state_nxt     = StShift;
                        w_bit_cnt_nxt   = '0;
                        w_div_nxt       = '0;
                        w_ser_valid_nxt = 1'b1;
                        w_ser_first_nxt = 1'b1;
                        w_ser_last_nxt  = 1'b0;
                        w_ser_out_nxt   = w_shift_nxt[WIDTH-1];
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    end
                end
            end
            StShift: begin
                if (r_div == DivLast) begin
                    w_div_nxt = '0;
                    if (r_bit_cnt == BitLast) begin
                        // Final bit period done: return to idle level.
                        w_state_nxt     = StLoad;
                        w_bit_cnt_nxt   = '0;
                        w_shift_nxt     = '0;
                        w_ser_out_nxt   = 1'b0;
                        w_ser_valid_nxt = 1'b0;
                        w_ser_first_nxt = 1'b0;
                        w_ser_last_nxt  = 1'b0;
                    end else begin
                        w_bit_cnt_nxt   = r_bit_cnt + 1'b1;
                        w_shift_nxt     = w_shifted;
                        w_ser_out_nxt   = w_shifted[WIDTH-1];
                        w_ser_first_nxt = 1'b0;
                        w_ser_last_nxt  = (r_bit_cnt == BitPenult);
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: w_state_nxt = StLoad;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StLoad;
            r_byte_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_div       <= '0;
            r_shift     <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_first <= 1'b0;
            r_ser_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_div       <= w_div_nxt;
            r_shift     <= w_shift_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_ser_first <= w_ser_first_nxt;
            r_ser_last  <= w_ser_last_nxt;
        end
    end

    assign in_ready  = (r_state == StLoad);
    assign busy      = (r_state == StShift);
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign ser_first = r_ser_first;
    assign ser_last  = r_ser_last;

endmodule
